// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
package nibble_serial_adder_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Index counter width; a single-nibble operand still needs one bit.
    function automatic int idx_width(input int words);
        return (words <= 1) ? 1 : $clog2(words);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Request/result handshake bundle between a requester and the nibble-serial adder.
interface nibble_serial_adder_ctrl_if
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int WORDS = 4
);
    localparam int W = NIBBLE_W * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/nibble_serial_adder_ctrl_adder.sv
// Shared 4-bit ripple-carry adder datapath.
module fourBitAdder_FourByOne (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic carry;

    always_comb begin
        carry = cin;
        s     = '0;
        for (int i = 0; i < 4; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Sequences one shared 4-bit adder over WORDS nibbles, LSB first, with carry kept
// between nibbles; reports carry-out and signed overflow of the full-width result.
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    nibble_serial_adder_ctrl_if.slave    bus
);
    localparam int W  = NIBBLE_W * WORDS;
    localparam int IW = idx_width(WORDS);

    localparam logic [1:0] IDLE = 2'(ST_IDLE);
    localparam logic [1:0] RUN  = 2'(ST_RUN);
    localparam logic [1:0] DONE = 2'(ST_DONE);

    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    logic [1:0]          state;
    logic [IW-1:0]       idx_q;
    logic                carry_q;
    logic [W-1:0]        a_q;
    logic [W-1:0]        b_q;
    logic [W-1:0]        sum_q;
    logic                cout_q;
    logic                ovf_q;

    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] s_nib;
    logic                c_nib;
    logic                last;

    assign a_nib = a_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];
    assign b_nib = b_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];
    assign last  = (idx_q == LAST_IDX);

    fourBitAdder_FourByOne u_adder (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .s    (s_nib),
        .cout (c_nib)
    );

    // Operands are pure data: captured at acceptance, never reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.in_valid) begin
            a_q <= bus.a;
            b_q <= bus.sub ? ~bus.b : bus.b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        carry_q <= bus.sub ? 1'b1 : bus.cin;
                        idx_q   <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    sum_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W] <= s_nib;
                    carry_q <= c_nib;
                    idx_q   <= idx_q + 1'b1;
                    if (last) begin
                        cout_q <= c_nib;
                        // Signed overflow: like-signed operands producing a different sign.
                        ovf_q  <= (a_nib[NIBBLE_W-1] == b_nib[NIBBLE_W-1]) &&
                                  (s_nib[NIBBLE_W-1] != a_nib[NIBBLE_W-1]);
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl at WORDS=4 and WORDS=1 against an arithmetic model.
module tb_nibble_serial_adder_ctrl;
    import nibble_serial_adder_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_ctrl_if #(.WORDS(4)) bus4 ();
    nibble_serial_adder_ctrl_if #(.WORDS(1)) bus1 ();

    nibble_serial_adder_ctrl #(.WORDS(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    nibble_serial_adder_ctrl #(.WORDS(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    task automatic check(input string tag, input string what,
                         input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s.%s observed=0x%0h expected=0x%0h", tag, what, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on w-bit operands.
    function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic cin, input logic sub,
                                  output logic [63:0] s, output logic co, output logic ov);
        longint unsigned mask;
        longint unsigned tot;
        longint          lim;
        longint          sa;
        longint          sb;
        longint          r;
        mask = (64'd1 << w) - 64'd1;
        lim  = longint'(64'd1 << (w - 1));
        sa   = a[w-1] ? longint'(a) - 2 * lim : longint'(a);
        sb   = b[w-1] ? longint'(b) - 2 * lim : longint'(b);
        if (sub) begin
            tot = (a - b) & mask;
            co  = (a >= b);
            r   = sa - sb;
        end else begin
            tot = a + b + 64'(cin);
            co  = ((tot >> w) & 64'd1) != 64'd0;
            tot = tot & mask;
            r   = sa + sb + longint'(cin);
        end
        ov = (r >= lim) || (r < -lim);
        s  = tot;
    endfunction

    task automatic op4(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub, input int hold);
        logic [63:0] es;
        logic        ec;
        logic        eo;
        model(16, 64'(a), 64'(b), cin, sub, es, ec, eo);
        check(tag, "in_ready_idle", 64'(bus4.in_ready), 64'd1);
        bus4.in_valid = 1'b1;
        bus4.a        = a;
        bus4.b        = b;
        bus4.cin      = cin;
        bus4.sub      = sub;
        step();
        check(tag, "in_ready_run", 64'(bus4.in_ready), 64'd0);
        repeat (4) begin
            check(tag, "out_valid_early", 64'(bus4.out_valid), 64'd0);
            bus4.a   = 16'($urandom);
            bus4.b   = 16'($urandom);
            bus4.cin = 1'($urandom);
            bus4.sub = 1'($urandom);
            step();
        end
        bus4.in_valid = 1'b0;
        check(tag, "out_valid", 64'(bus4.out_valid), 64'd1);
        check(tag, "sum", 64'(bus4.sum), es);
        check(tag, "cout", 64'(bus4.cout), 64'(ec));
        check(tag, "ovf", 64'(bus4.ovf), 64'(eo));
        for (int h = 0; h < hold; h++) begin
            step();
            check(tag, "hold_valid", 64'(bus4.out_valid), 64'd1);
            check(tag, "hold_in_ready", 64'(bus4.in_ready), 64'd0);
            check(tag, "hold_sum", 64'(bus4.sum), es);
            check(tag, "hold_cout", 64'(bus4.cout), 64'(ec));
            check(tag, "hold_ovf", 64'(bus4.ovf), 64'(eo));
        end
        bus4.out_ready = 1'b1;
        step();
        bus4.out_ready = 1'b0;
        check(tag, "out_valid_after", 64'(bus4.out_valid), 64'd0);
        check(tag, "in_ready_after", 64'(bus4.in_ready), 64'd1);
    endtask

    task automatic op1(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic cin, input logic sub);
        logic [63:0] es;
        logic        ec;
        logic        eo;
        model(4, 64'(a), 64'(b), cin, sub, es, ec, eo);
        check(tag, "in_ready_idle", 64'(bus1.in_ready), 64'd1);
        bus1.in_valid = 1'b1;
        bus1.a        = a;
        bus1.b        = b;
        bus1.cin      = cin;
        bus1.sub      = sub;
        step();
        bus1.a = 4'($urandom);
        bus1.b = 4'($urandom);
        check(tag, "out_valid_early", 64'(bus1.out_valid), 64'd0);
        step();
        bus1.in_valid = 1'b0;
        check(tag, "out_valid", 64'(bus1.out_valid), 64'd1);
        check(tag, "sum", 64'(bus1.sum), es);
        check(tag, "cout", 64'(bus1.cout), 64'(ec));
        check(tag, "ovf", 64'(bus1.ovf), 64'(eo));
        bus1.out_ready = 1'b1;
        step();
        bus1.out_ready = 1'b0;
        check(tag, "out_valid_after", 64'(bus1.out_valid), 64'd0);
        check(tag, "in_ready_after", 64'(bus1.in_ready), 64'd1);
    endtask

    initial begin
        rst            = 1'b1;
        bus4.in_valid  = 1'b0;
        bus4.a         = '0;
        bus4.b         = '0;
        bus4.cin       = 1'b0;
        bus4.sub       = 1'b0;
        bus4.out_ready = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.a         = '0;
        bus1.b         = '0;
        bus1.cin       = 1'b0;
        bus1.sub       = 1'b0;
        bus1.out_ready = 1'b0;
        step();
        step();
        check("reset", "in_ready", 64'(bus4.in_ready), 64'd1);
        check("reset", "out_valid", 64'(bus4.out_valid), 64'd0);
        check("reset", "sum", 64'(bus4.sum), 64'd0);
        check("reset", "cout", 64'(bus4.cout), 64'd0);
        check("reset", "ovf", 64'(bus4.ovf), 64'd0);
        check("reset1", "in_ready", 64'(bus1.in_ready), 64'd1);
        check("reset1", "out_valid", 64'(bus1.out_valid), 64'd0);
        rst = 1'b0;
        step();

        op4("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        op4("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 3);
        op4("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 0);
        op4("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 1);
        op4("add_cin", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 0);
        op4("sub_cin_ignored", 16'h1000, 16'h1000, 1'b1, 1'b1, 0);

        // Out_ready pulsed while nothing is valid must be harmless.
        bus4.out_ready = 1'b1;
        step();
        bus4.out_ready = 1'b0;
        check("idle_out_ready", "out_valid", 64'(bus4.out_valid), 64'd0);
        check("idle_out_ready", "in_ready", 64'(bus4.in_ready), 64'd1);

        // Reset in the 2nd RUN cycle discards the operation.
        bus4.in_valid = 1'b1;
        bus4.a        = 16'h1111;
        bus4.b        = 16'h2222;
        bus4.cin      = 1'b0;
        bus4.sub      = 1'b0;
        step();
        bus4.in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("mid_reset", "out_valid", 64'(bus4.out_valid), 64'd0);
        check("mid_reset", "in_ready", 64'(bus4.in_ready), 64'd1);
        check("mid_reset", "sum", 64'(bus4.sum), 64'd0);
        check("mid_reset", "cout", 64'(bus4.cout), 64'd0);
        check("mid_reset", "ovf", 64'(bus4.ovf), 64'd0);
        rst = 1'b0;
        repeat (5) begin
            step();
            check("post_reset", "out_valid", 64'(bus4.out_valid), 64'd0);
            check("post_reset", "in_ready", 64'(bus4.in_ready), 64'd1);
        end
        op4("after_reset", 16'h1234, 16'h4321, 1'b0, 1'b0, 0);
        check("after_reset", "sum_const", 64'(bus4.sum), 64'h5555);

        for (int i = 0; i < 20; i++) begin
            op4("rand4", 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 2)));
        end

        op1("w1_add", 4'hF, 4'h1, 1'b1, 1'b0);
        op1("w1_sub", 4'h8, 4'h1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            op1("rand1", 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
